// File: rtl/dbg_uart_bridge_if.sv
// Byte-stream (rx/tx) and SoC debug-port signal bundle for dbg_uart_bridge.
// master = the bridge, slave = the UART/SoC side.
interface dbg_uart_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_din;
    logic                  dbg_wr_en;
    logic                  dbg_req;
    logic [DATA_WIDTH-1:0] dbg_dout;
    logic                  dbg_ack;
    logic                  busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, dbg_dout, dbg_ack,
        output rx_ready, tx_data, tx_valid, dbg_addr, dbg_din, dbg_wr_en, dbg_req, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dbg_dout, dbg_ack,
        input  rx_ready, tx_data, tx_valid, dbg_addr, dbg_din, dbg_wr_en, dbg_req, busy
    );
endinterface

// File: rtl/dbg_uart_bridge.sv
// Decodes host command packets from a UART byte stream into single debug-port
// read/write transactions and returns status plus read data as bytes.
module dbg_uart_bridge #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    dbg_uart_bridge_if.master bus
);
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [7:0] RSV_MASK   = 8'((8'h7F >> ADDR_WIDTH) << ADDR_WIDTH);
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        REQ,
        RESP_STATUS,
        RESP_DATA
    } state_t;

    state_t                state;
    logic                  wr;
    logic                  timed_out;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [IDX_W-1:0]      byte_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  rx_ready;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  dbg_req;
    logic                  busy;

    logic                  rx_hs;
    logic                  tx_hs;
    logic [IDX_W-1:0]      idx_nxt;

    assign rx_hs   = bus.rx_valid & rx_ready;
    assign tx_hs   = tx_valid & bus.tx_ready;
    assign idx_nxt = byte_idx + 1'b1;

    // Packet FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr        <= 1'b0;
            timed_out <= 1'b0;
            addr      <= '0;
            din       <= '0;
            rd_data   <= '0;
            byte_idx  <= '0;
            cnt       <= '0;
            rx_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            dbg_req   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    // Commands with reserved bits set are swallowed silently.
                    if (rx_hs && ((bus.rx_data & RSV_MASK) == 8'h00)) begin
                        wr   <= bus.rx_data[7];
                        addr <= bus.rx_data[ADDR_WIDTH-1:0];
                        busy <= 1'b1;
                        if (bus.rx_data[7]) begin
                            state    <= RX_DATA;
                            byte_idx <= '0;
                        end else begin
                            state    <= REQ;
                            rx_ready <= 1'b0;
                            dbg_req  <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end

                RX_DATA: begin
                    if (rx_hs) begin
                        din[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                        if (byte_idx == IDX_LAST) begin
                            state    <= REQ;
                            rx_ready <= 1'b0;
                            dbg_req  <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            byte_idx <= idx_nxt;
                        end
                    end
                end

                REQ: begin
                    cnt <= cnt + 1'b1;
                    // Ack has priority over a timeout expiring in the same cycle.
                    if (bus.dbg_ack) begin
                        if (!wr) rd_data <= bus.dbg_dout;
                        timed_out <= 1'b0;
                        dbg_req   <= 1'b0;
                        tx_valid  <= 1'b1;
                        tx_data   <= ST_OK;
                        state     <= RESP_STATUS;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        timed_out <= 1'b1;
                        dbg_req   <= 1'b0;
                        tx_valid  <= 1'b1;
                        tx_data   <= ST_TIMEOUT;
                        state     <= RESP_STATUS;
                    end
                end

                RESP_STATUS: begin
                    if (tx_hs) begin
                        if (!wr && !timed_out) begin
                            state    <= RESP_DATA;
                            byte_idx <= '0;
                            tx_data  <= rd_data[7:0];
                        end else begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                        end
                    end
                end

                RESP_DATA: begin
                    if (tx_hs) begin
                        if (byte_idx == IDX_LAST) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                        end else begin
                            byte_idx <= idx_nxt;
                            tx_data  <= rd_data[{idx_nxt, 3'b000} +: 8];
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    dbg_req  <= 1'b0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_data;
    assign bus.dbg_req   = dbg_req;
    assign bus.dbg_wr_en = wr;
    assign bus.dbg_addr  = addr;
    assign bus.dbg_din   = din;
    assign bus.busy      = busy;
endmodule

// File: doc/dbg_uart_bridge.md
# dbg_uart_bridge

Byte-stream to debug-port bridge for the FPGA top level. It replaces the tied-off debug inputs of the SoC with a host-driven path. It decodes command packets arriving from a UART receiver's byte interface and issues single read or write transactions on the SoC debug port. It returns status and read data as bytes to a UART transmitter. Address and data widths are parametrised, and a configurable acknowledge timeout prevents a hung SoC from locking the host link.

## Interface
- ADDR_WIDTH, 2, debug register address width; legal range 1..7.
- DATA_WIDTH, 32, debug data width; must be a multiple of 8; DATA_BYTES = DATA_WIDTH/8.
- TIMEOUT, 1024, clk cycles to wait for dbg_ack after dbg_req rises; 0 disables the timeout.

Ports:
- clk  in  1  system clock (all logic on rising edge).
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx_data; a transfer occurs when rx_valid & rx_ready.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts; a transfer occurs when tx_valid & tx_ready.
- dbg_addr  out  ADDR_WIDTH  debug address.
- dbg_din  out  DATA_WIDTH  write data to the SoC.
- dbg_wr_en  out  1  1 = write, 0 = read.
- dbg_req  out  1  transaction request (level).
- dbg_dout  in  DATA_WIDTH  read data from the SoC, valid when dbg_ack = 1.
- dbg_ack  in  1  transaction complete.
- busy  out  1  high in every state except IDLE.

## Operation
- Command byte: bit7 = W (1 write, 0 read); bits[ADDR_WIDTH-1:0] = address; bits[6:ADDR_WIDTH] must be 0.
  - A command byte with nonzero reserved bits is consumed and dropped; the bridge stays in IDLE and sends no response.
- Write packet: command followed by DATA_BYTES data bytes, least-significant first. Response: one status byte.
- Read packet: command only. Response: status byte; if status is OK, DATA_BYTES data bytes follow, least-significant first.
- Status codes: 0x00 = OK, 0xEE = timeout. A timed-out read returns 0xEE only, with no data bytes.
- States:
  - IDLE: rx_ready = 1. A valid command latches addr and W. W = 1 goes to RX_DATA with byte count 0; W = 0 goes to REQ.
  - RX_DATA: rx_ready = 1. Each accepted byte shifts into dbg_din[8k+7:8k]. After byte DATA_BYTES-1 is accepted, go to REQ.
  - REQ: rx_ready = 0. dbg_req = 1, dbg_wr_en = W, dbg_addr and dbg_din are held stable. The timeout counter increments each cycle.
    - dbg_ack = 1: capture dbg_dout when W = 0, set status 0x00, go to RESP_STATUS.
    - Counter reaches TIMEOUT with no ack: set status 0xEE, go to RESP_STATUS.
    - Ack and timeout in the same cycle: ack wins.
  - RESP_STATUS: tx_valid = 1, tx_data = status. On handshake: if W = 0 and status is OK, go to RESP_DATA with index 0; otherwise go to IDLE.
  - RESP_DATA: tx_data = captured read data byte[index]. On handshake, index increments; after byte DATA_BYTES-1 is sent, go to IDLE.
- tx_data and tx_valid remain stable while tx_valid = 1 and tx_ready = 0.
- Bytes offered on rx while in REQ, RESP_STATUS or RESP_DATA are not accepted (backpressure); none are lost.
- Reset values: rx_ready = 0 while rst_n = 0, and 1 from the first clock after release. All other outputs are 0: tx_valid, tx_data, dbg_req, dbg_wr_en, dbg_addr, dbg_din, busy. State = IDLE.
- rst_n asserted mid-transaction aborts immediately. dbg_req drops asynchronously and no response is sent.

## Timing
- Write: last data byte accepted at edge N; dbg_req = 1 from N+1.
- Read: command accepted at edge N; dbg_req = 1 from N+1.
- dbg_ack sampled high at edge M: dbg_req = 0 and tx_valid = 1 (status) from M+1. dbg_req is never high in the cycle after ack is sampled.
- Timeout: dbg_req high for exactly TIMEOUT cycles, then tx_valid = 1 with 0xEE on the next cycle.
- The next status/data byte is presented in the cycle after each tx handshake. Sustained throughput is 1 byte/cycle when tx_ready is held high.
- IDLE is re-entered in the cycle after the final response handshake. A new command can be accepted in that same cycle.

## Test plan
- Write: rx 0x81, 0x78, 0x56, 0x34, 0x12 -> dbg_req with wr_en = 1, addr = 1, din = 0x12345678. Ack after 3 cycles -> tx 0x00 only.
- Read: rx 0x02 with dbg_dout = 0xDEADBEEF at ack -> tx 0x00, 0xEF, 0xBE, 0xAD, 0xDE, each byte held under random tx_ready stalls.
- Timeout: TIMEOUT = 16, rx 0x03, ack never asserted -> dbg_req high for exactly 16 cycles, tx 0xEE, no data bytes, returns to IDLE.
- Reserved bits: rx 0x44 (ADDR_WIDTH = 2) -> no dbg_req and no tx. A following 0x00 then performs a normal read of addr 0.
- Backpressure and reset: rx_valid held during REQ -> rx_ready = 0 and the byte is accepted only after the response completes. rst_n pulsed during REQ -> dbg_req = 0 immediately, all outputs reset, no tx.
- Ack/timeout tie: TIMEOUT = 4, ack arrives on cycle 4 -> status 0x00 and read data returned.
